ext_arbiter: RTL

- Shares one immediate extender among `NREQ` requesters, e.g. decode-stage immediate and branch-offset generation.
- Arbitrates valid/ready requests round-robin and computes the 32-bit extension of the granted 16-bit immediate per its 2-bit `EOp`.
- Registers the result with the winner's index in a one-entry output buffer.
- Sits between the requesting units and the consumers of the extended operand in the datapath.

---
 rtl/ext_pkg.sv | 19 +
 rtl/ext_rr_pick.sv | 52 +++++
 rtl/ext_unit.sv | 34 +++
 rtl/ext_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ext_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ext_pkg
// Description : Shared constants for the immediate-extension arbiter slice.
//               EOp encodings and the immediate / result data widths.
// Revision    : 1.0 - initial release
// ============================================================================
package ext_pkg;

  localparam int IMM_W  = 16;
  localparam int DATA_W = 32;

  localparam logic [1:0] EXT_SIGN     = 2'b00;  // sign-extend
  localparam logic [1:0] EXT_ZERO     = 2'b01;  // zero-extend
  localparam logic [1:0] EXT_LUI      = 2'b10;  // {imm, 16'h0}
  localparam logic [1:0] EXT_SIGN_SL2 = 2'b11;  // sign-extend, shift left 2

endpackage : ext_pkg
`default_nettype wire

// File: rtl/ext_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : ext_rr_pick
// Description : Combinational round-robin picker. Selects the first valid
//               requester scanning upward from ptr with wrap-around.
// Ports       : valid - per-requester valid
//               ptr   - highest-priority requester index (< NREQ)
//               grant - one-hot grant (zero when no valid)
//               idx   - winner index
//               any   - some requester is valid
// Revision    : 1.0 - initial release
// ============================================================================
module ext_rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int w_best;
  int w_dist;

  // Each candidate's priority is its circular distance from ptr; the
  // smallest distance among valid requesters wins.
  always_comb begin
    w_best = NREQ;
    w_dist = 0;
    idx    = '0;
    any    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      w_dist = i - int'(ptr);
      if (w_dist < 0) begin
        w_dist = w_dist + NREQ;
      end
      if (valid[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        idx    = IDW'(i);
        any    = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
    assign grant[gi] = any && (idx == IDW'(gi));
  end

endmodule : ext_rr_pick
`default_nettype wire

// File: rtl/ext_unit.sv
`default_nettype none
// ============================================================================
// Module      : ext_unit
// Description : Combinational 16->32 bit immediate extender.
// Ports       : imm  - 16-bit immediate
//               eop  - 2-bit extension operation
//               data - 32-bit extended result
// Revision    : 1.0 - initial release
// ============================================================================
module ext_unit
  import ext_pkg::*;
(
  input  logic [IMM_W-1:0]  imm,
  input  logic [1:0]        eop,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] w_sext;

  assign w_sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

  always_comb begin
    data = w_sext;
    case (eop)
      EXT_SIGN:     data = w_sext;
      EXT_ZERO:     data = {{(DATA_W-IMM_W){1'b0}}, imm};
      EXT_LUI:      data = {imm, {(DATA_W-IMM_W){1'b0}}};
      EXT_SIGN_SL2: data = {w_sext[DATA_W-3:0], 2'b00};  // top two bits drop out
      default:      data = w_sext;
    endcase
  end

endmodule : ext_unit
`default_nettype wire

// File: rtl/ext_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ext_arbiter
// Description : Shares one immediate extender among NREQ requesters using
//               round-robin valid/ready arbitration, and buffers the
//               extended result with the winner index in a one-entry
//               output register.
// Ports       : clk, rst_n          - clock, async active-low reset
//               req_valid/req_ready - per-requester handshake
//               req_imm, req_eop    - packed immediates / EOps
//               out_valid/out_ready - result handshake
//               out_data, out_id    - extended immediate and its source
//               stat_sel, stat_cnt  - grant counter readback
//                                     (only with EXT_ARB_STATS_EN)
// Revision    : 1.0 - initial release
// ============================================================================
module ext_arbiter
  import ext_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [IMM_W*NREQ-1:0] req_imm,
  input  logic [2*NREQ-1:0]     req_eop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [IDW-1:0]        out_id
`ifdef EXT_ARB_STATS_EN
  ,
  input  logic [IDW-1:0]        stat_sel,
  output logic [15:0]           stat_cnt
`endif
);

  localparam logic [IDW-1:0] c_last  = IDW'(NREQ - 1);
  localparam logic [0:0]     S_EMPTY = 1'b0;
  localparam logic [0:0]     S_FULL  = 1'b1;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [IDW-1:0]    r_rr_ptr;
  logic [NREQ-1:0]   w_grant;
  logic [IDW-1:0]    w_win;
  logic              w_any;
  logic              w_accept;
  logic              w_fire;
  logic [IMM_W-1:0]  w_imm;
  logic [1:0]        w_eop;
  logic [DATA_W-1:0] w_ext;
  logic [DATA_W-1:0] r_data;
  logic [IDW-1:0]    r_id;

  ext_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .valid (req_valid),
    .ptr   (r_rr_ptr),
    .grant (w_grant),
    .idx   (w_win),
    .any   (w_any)
  );

  // The buffer can take a new result when empty or draining this cycle.
  assign w_accept  = (r_state == S_EMPTY) || out_ready;
  assign w_fire    = w_accept && w_any;
  assign req_ready = w_accept ? w_grant : '0;

  // Winner operand mux; the one-hot grant selects at most one slice.
  always_comb begin
    w_imm = '0;
    w_eop = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_imm = req_imm[IMM_W*i +: IMM_W];
        w_eop = req_eop[2*i +: 2];
      end
    end
  end

  ext_unit u_ext (
    .imm  (w_imm),
    .eop  (w_eop),
    .data (w_ext)
  );

  // Pointer advances past the winner; with NREQ=1 c_last is 0 and the
  // pointer stays at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_fire) begin
      r_rr_ptr <= (w_win == c_last) ? '0 : w_win + 1'b1;
    end
  end

  // Output buffer state machine: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: a grant always leaves the buffer full (including the
  // simultaneous drain-and-reload case).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_fire)         w_state_nxt = S_FULL;
      S_FULL:  if (w_fire)         w_state_nxt = S_FULL;
               else if (out_ready) w_state_nxt = S_EMPTY;
      default:                     w_state_nxt = S_EMPTY;
    endcase
  end

  // Outputs.
  always_comb begin
    out_valid = (r_state == S_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_id   <= '0;
    end else if (w_fire) begin
      r_data <= w_ext;
      r_id   <= w_win;
    end
  end

  assign out_data = r_data;
  assign out_id   = r_id;

`ifdef EXT_ARB_STATS_EN
  localparam logic [15:0] c_cnt_max = 16'hFFFF;

  logic [15:0] r_cnt [NREQ];
  logic [15:0] w_sel_cnt;
  logic [15:0] r_stat;

  // Saturating per-requester grant counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_fire && (w_win == IDW'(i)) && (r_cnt[i] != c_cnt_max)) begin
          r_cnt[i] <= r_cnt[i] + 16'd1;
        end
      end
    end
  end

  // Out-of-range selects read as zero.
  always_comb begin
    w_sel_cnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (stat_sel == IDW'(i)) begin
        w_sel_cnt = r_cnt[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat <= '0;
    end else begin
      r_stat <= w_sel_cnt;
    end
  end

  assign stat_cnt = r_stat;
`endif

endmodule : ext_arbiter
`default_nettype wire
